// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: a chain of DEPTH elastic register stages, each WIDTH bits,
// with valid/ready handshakes on both ends.
// Empty stages are filled as data advances, so bubbles collapse even while the
// output is stalled. A synchronous flush clears every stage.
// Optional feature macro: PIPE_REG_CHAIN_OCC_EN adds an occupancy output
// (popcount of the per-stage valid bits).
module pipe_reg_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];

   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_valid;
   logic [WIDTH-1:0] src_data [DEPTH];

   // Ready ripples back from the output: a stage can take new data if it is
   // empty or if everything downstream of it is moving this cycle.
   always_comb begin
      rdy = '0;
      rdy[DEPTH-1] = !valid[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         rdy[i] = !valid[i] | rdy[i+1];
      end
   end

   // Each stage's source is the upstream stage; stage 0 is fed by the input port.
   always_comb begin
      src_valid[0] = in_valid;
      src_data[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_valid[i] = valid[i-1];
         src_data[i]  = data[i-1];
      end
   end

   // Stage registers. Reset clears valid and data. Flush clears only valid, so
   // an input taken on the flush cycle is dropped. Data is written only when
   // the incoming item is valid; otherwise it holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
               valid[i] <= 1'b0;
            end else if (rdy[i]) begin
               valid[i] <= src_valid[i];
            end
            if (rdy[i] && src_valid[i]) begin
               data[i] <= src_data[i];
            end
         end
      end
   end

   // Port views of the chain ends.
   always_comb begin
      in_ready  = rdy[0];
      out_valid = valid[DEPTH-1];
      out_data  = data[DEPTH-1];
   end

`ifdef PIPE_REG_CHAIN_OCC_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   // Number of stages currently holding an item.
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(valid[i]);
      end
   end
`endif

endmodule
